// File: rtl/axi_w_router_if.sv
// rtl/axi_w_router_if.sv - AXI W-channel router bus bundle (AW select push, master W, slave W, status)
interface axi_w_router_if #(
   parameter int NUM_SLAVES = 4,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_DEPTH  = 4
);
   localparam int SEL_W = $clog2(NUM_SLAVES);
   localparam int CNT_W = $clog2(SEL_DEPTH + 1);

   logic                      aw_push_i;
   logic [SEL_W-1:0]          aw_sel_i;
   logic                      aw_full_o;
   logic [DATA_WIDTH-1:0]     m_wdata_i;
   logic [DATA_WIDTH/8-1:0]   m_wstrb_i;
   logic                      m_wlast_i;
   logic                      m_wvalid_i;
   logic                      m_wready_o;
   logic [DATA_WIDTH-1:0]     s_wdata_o;
   logic [DATA_WIDTH/8-1:0]   s_wstrb_o;
   logic                      s_wlast_o;
   logic [NUM_SLAVES-1:0]     s_wvalid_o;
   logic [NUM_SLAVES-1:0]     s_wready_i;
   logic [CNT_W-1:0]          outstanding_o;
   logic                      decerr_o;
   logic                      ovf_o;

   modport slave (
      input  aw_push_i, aw_sel_i, m_wdata_i, m_wstrb_i, m_wlast_i, m_wvalid_i, s_wready_i,
      output aw_full_o, m_wready_o, s_wdata_o, s_wstrb_o, s_wlast_o, s_wvalid_o,
             outstanding_o, decerr_o, ovf_o
   );

   modport master (
      output aw_push_i, aw_sel_i, m_wdata_i, m_wstrb_i, m_wlast_i, m_wvalid_i, s_wready_i,
      input  aw_full_o, m_wready_o, s_wdata_o, s_wstrb_o, s_wlast_o, s_wvalid_o,
             outstanding_o, decerr_o, ovf_o
   );
endinterface

// File: rtl/axi_w_router.sv
// rtl/axi_w_router.sv - routes W beats to the slave chosen by the oldest outstanding AW
module axi_w_router #(
   parameter int  NUM_SLAVES = 4,
   parameter int  DATA_WIDTH = 32,
   parameter int  SEL_DEPTH  = 4,
   localparam int SEL_W      = $clog2(NUM_SLAVES),
   localparam int CNT_W      = $clog2(SEL_DEPTH + 1),
   localparam int PTR_W      = (SEL_DEPTH > 1) ? $clog2(SEL_DEPTH) : 1
) (
   input logic             clk_i,
   input logic             rst_ni,
   axi_w_router_if.slave   bus
);
   logic [SEL_W-1:0]      mem_q [SEL_DEPTH];
   logic [SEL_W-1:0]      mem_d [SEL_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  decerr_q, decerr_d;

   logic                  empty, full, head_ok, wready, push, pop;
   logic [SEL_W-1:0]      head;
   logic [NUM_SLAVES-1:0] wvalid_vec;
   logic [DATA_WIDTH-1:0] wdata;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(SEL_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(SEL_DEPTH));
   assign head    = mem_q[rd_ptr_q];
   assign head_ok = (32'(head) < NUM_SLAVES);

   // Head index outside the slave range turns the port into a sink that accepts every beat.
   always_comb begin
      wvalid_vec = '0;
      wready     = 1'b0;
      if (!empty) begin
         if (head_ok) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
               if (SEL_W'(i) == head) begin
                  wvalid_vec[i] = bus.m_wvalid_i;
                  wready        = bus.s_wready_i[i];
               end
            end
         end else begin
            wready = 1'b1;
         end
      end
   end

   // A retiring burst frees its slot in the same cycle, so a full FIFO can still take a push.
   assign pop  = !empty && bus.m_wvalid_i && wready && bus.m_wlast_i;
   assign push = bus.aw_push_i && (!full || pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = bus.aw_sel_i;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      ovf_d    = ovf_q || (bus.aw_push_i && !push);
      decerr_d = pop && !head_ok;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SEL_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         decerr_q <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         decerr_q <= decerr_d;
      end
   end

   assign wdata             = bus.m_wdata_i;
   assign bus.s_wdata_o     = wdata;
   assign bus.s_wstrb_o     = bus.m_wstrb_i;
   assign bus.s_wlast_o     = bus.m_wlast_i;
   assign bus.s_wvalid_o    = wvalid_vec;
   assign bus.m_wready_o    = wready;
   assign bus.aw_full_o     = full;
   assign bus.outstanding_o = cnt_q;
   assign bus.decerr_o      = decerr_q;
   assign bus.ovf_o         = ovf_q;
endmodule

// File: tb/tb_axi_w_router.sv
// tb/tb_axi_w_router.sv - bench for axi_w_router: vector table, directed corner sequences, random vs queue model
module tb_axi_w_router;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   axi_w_router_if #(.NUM_SLAVES(4), .DATA_WIDTH(32), .SEL_DEPTH(4)) w4 ();
   axi_w_router_if #(.NUM_SLAVES(3), .DATA_WIDTH(32), .SEL_DEPTH(4)) w3 ();

   axi_w_router #(.NUM_SLAVES(4), .DATA_WIDTH(32), .SEL_DEPTH(4)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .bus(w4));
   axi_w_router #(.NUM_SLAVES(3), .DATA_WIDTH(32), .SEL_DEPTH(4)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n), .bus(w3));

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [1:0] sel;
      logic       wvalid;
      logic [3:0] wready;
      logic [3:0] exp_sv;
      logic       exp_wr;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_all();
      w4.aw_push_i = 0; w4.aw_sel_i = 0; w4.m_wvalid_i = 0; w4.m_wlast_i = 0;
      w4.m_wdata_i = 0; w4.m_wstrb_i = 0; w4.s_wready_i = 0;
      w3.aw_push_i = 0; w3.aw_sel_i = 0; w3.m_wvalid_i = 0; w3.m_wlast_i = 0;
      w3.m_wdata_i = 0; w3.m_wstrb_i = 0; w3.s_wready_i = 0;
   endtask

   task automatic do_reset();
      idle_all();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic push4(input logic [1:0] s);
      w4.aw_push_i = 1'b1;
      w4.aw_sel_i  = s;
      tick();
      w4.aw_push_i = 1'b0;
   endtask

   int        order[4];
   int        q[$];
   logic      pend_decerr;
   logic      ovf_m;
   logic      hs;
   logic [2:0] exp_sv3;
   logic      exp_wr3;
   logic      pop_m;
   logic      acc_m;

   initial begin
      vecs[0] = '{2'd0, 1'b1, 4'b0001, 4'b0001, 1'b1};
      vecs[1] = '{2'd1, 1'b1, 4'b0000, 4'b0010, 1'b0};
      vecs[2] = '{2'd2, 1'b0, 4'b0100, 4'b0000, 1'b1};
      vecs[3] = '{2'd3, 1'b1, 4'b1000, 4'b1000, 1'b1};
      vecs[4] = '{2'd3, 1'b1, 4'b0111, 4'b1000, 1'b0};
      vecs[5] = '{2'd1, 1'b1, 4'b1101, 4'b0010, 1'b0};
      vecs[6] = '{2'd2, 1'b1, 4'b1111, 4'b0100, 1'b1};
      vecs[7] = '{2'd0, 1'b0, 4'b1110, 4'b0000, 1'b0};

      // Reset values, with master valid asserted to show it is ignored when empty
      idle_all();
      rst_n = 1'b0;
      w4.m_wvalid_i = 1'b1;
      w4.s_wready_i = 4'hF;
      tick();
      settle();
      chk("rst_outstanding", 32'(w4.outstanding_o), 0);
      chk("rst_full", 32'(w4.aw_full_o), 0);
      chk("rst_wready", 32'(w4.m_wready_o), 0);
      chk("rst_svalid", 32'(w4.s_wvalid_o), 0);
      chk("rst_decerr", 32'(w4.decerr_o), 0);
      chk("rst_ovf", 32'(w4.ovf_o), 0);
      do_reset();

      // Single-beat burst to slave 2; no bypass on the push cycle
      w4.aw_push_i = 1'b1; w4.aw_sel_i = 2'd2;
      w4.m_wvalid_i = 1'b1; w4.m_wlast_i = 1'b1; w4.s_wready_i = 4'b0100;
      w4.m_wdata_i = 32'hDEADBEEF; w4.m_wstrb_i = 4'hF;
      settle();
      chk("t1_nobypass_sv", 32'(w4.s_wvalid_o), 0);
      chk("t1_nobypass_wr", 32'(w4.m_wready_o), 0);
      tick();
      w4.aw_push_i = 1'b0;
      settle();
      chk("t1_sv", 32'(w4.s_wvalid_o), 32'b0100);
      chk("t1_wr", 32'(w4.m_wready_o), 1);
      chk("t1_wdata", w4.s_wdata_o, 32'hDEADBEEF);
      chk("t1_wlast", 32'(w4.s_wlast_o), 1);
      chk("t1_out1", 32'(w4.outstanding_o), 1);
      tick();
      w4.m_wvalid_i = 1'b0;
      settle();
      chk("t1_out0", 32'(w4.outstanding_o), 0);

      // Two outstanding bursts routed back-to-back
      idle_all();
      push4(2'd1);
      push4(2'd3);
      for (int b = 0; b < 6; b++) begin
         w4.m_wvalid_i = 1'b1; w4.s_wready_i = 4'hF;
         w4.m_wlast_i  = (b == 3 || b == 5);
         w4.m_wdata_i  = 32'(b);
         settle();
         chk($sformatf("t2_sv_b%0d", b), 32'(w4.s_wvalid_o), (b < 4) ? 32'b0010 : 32'b1000);
         chk($sformatf("t2_out_b%0d", b), 32'(w4.outstanding_o), (b < 4) ? 2 : 1);
         tick();
      end
      idle_all();
      settle();
      chk("t2_out_end", 32'(w4.outstanding_o), 0);

      // Vector table: one single-beat burst per row
      for (int i = 0; i < 8; i++) begin
         idle_all();
         push4(vecs[i].sel);
         w4.m_wvalid_i = vecs[i].wvalid; w4.m_wlast_i = 1'b1;
         w4.s_wready_i = vecs[i].wready; w4.m_wdata_i = $urandom;
         settle();
         chk($sformatf("vec%0d_sv", i), 32'(w4.s_wvalid_o), 32'(vecs[i].exp_sv));
         chk($sformatf("vec%0d_wr", i), 32'(w4.m_wready_o), 32'(vecs[i].exp_wr));
         chk($sformatf("vec%0d_wdata", i), w4.s_wdata_o, w4.m_wdata_i);
         hs = vecs[i].wvalid & vecs[i].exp_wr;
         tick();
         settle();
         chk($sformatf("vec%0d_out", i), 32'(w4.outstanding_o), hs ? 0 : 1);
         if (!hs) begin
            w4.m_wvalid_i = 1'b1; w4.s_wready_i = 4'hF;
            tick();
         end
      end

      // Fill to full, then an overflowing push
      do_reset();
      for (int i = 0; i < 4; i++) push4(2'(i));
      settle();
      chk("full_flag", 32'(w4.aw_full_o), 1);
      chk("full_out", 32'(w4.outstanding_o), 4);
      chk("full_ovf0", 32'(w4.ovf_o), 0);
      push4(2'd1);
      settle();
      chk("ovf_set", 32'(w4.ovf_o), 1);
      chk("ovf_out", 32'(w4.outstanding_o), 4);

      // Full FIFO: push coincident with head's WLAST handshake
      do_reset();
      push4(2'd1); push4(2'd2); push4(2'd3); push4(2'd3);
      w4.aw_push_i = 1'b1; w4.aw_sel_i = 2'd0;
      w4.m_wvalid_i = 1'b1; w4.m_wlast_i = 1'b1; w4.s_wready_i = 4'hF;
      settle();
      chk("pp_full_reg", 32'(w4.aw_full_o), 1);
      chk("pp_sv", 32'(w4.s_wvalid_o), 32'b0010);
      tick();
      w4.aw_push_i = 1'b0;
      settle();
      chk("pp_out", 32'(w4.outstanding_o), 4);
      chk("pp_ovf", 32'(w4.ovf_o), 0);
      order = '{2, 3, 3, 0};
      for (int k = 0; k < 4; k++) begin
         settle();
         chk($sformatf("pp_order%0d", k), 32'(w4.s_wvalid_o), 32'(1) << order[k]);
         tick();
      end
      idle_all();
      settle();
      chk("pp_drained", 32'(w4.outstanding_o), 0);

      // Sink mode on the 3-slave instance
      do_reset();
      w3.aw_push_i = 1'b1; w3.aw_sel_i = 2'd3;
      tick();
      w3.aw_push_i = 1'b0;
      w3.m_wvalid_i = 1'b1; w3.m_wlast_i = 1'b0; w3.s_wready_i = 3'b000;
      settle();
      chk("sink_sv", 32'(w3.s_wvalid_o), 0);
      chk("sink_wr", 32'(w3.m_wready_o), 1);
      chk("sink_decerr0", 32'(w3.decerr_o), 0);
      tick();
      w3.m_wlast_i = 1'b1;
      settle();
      chk("sink_decerr_last", 32'(w3.decerr_o), 0);
      tick();
      w3.m_wvalid_i = 1'b0;
      settle();
      chk("sink_decerr_pulse", 32'(w3.decerr_o), 1);
      chk("sink_out", 32'(w3.outstanding_o), 0);
      tick();
      settle();
      chk("sink_decerr_clr", 32'(w3.decerr_o), 0);

      // Asynchronous reset mid-burst with three outstanding
      do_reset();
      push4(2'd1); push4(2'd2); push4(2'd3);
      w4.m_wvalid_i = 1'b1; w4.m_wlast_i = 1'b0; w4.s_wready_i = 4'hF;
      settle();
      chk("mr_pre_sv", 32'(w4.s_wvalid_o), 32'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_out", 32'(w4.outstanding_o), 0);
      chk("mr_wr", 32'(w4.m_wready_o), 0);
      chk("mr_sv", 32'(w4.s_wvalid_o), 0);
      chk("mr_full", 32'(w4.aw_full_o), 0);
      tick();
      rst_n = 1'b1;
      settle();
      chk("mr_post_wr", 32'(w4.m_wready_o), 0);
      tick();
      settle();
      chk("mr_post_wr2", 32'(w4.m_wready_o), 0);
      push4(2'd2);
      settle();
      chk("mr_new_sv", 32'(w4.s_wvalid_o), 32'b0100);

      // Random traffic on the 3-slave instance against a queue model
      do_reset();
      q.delete();
      pend_decerr = 1'b0;
      ovf_m = 1'b0;
      for (int c = 0; c < 600; c++) begin
         w3.aw_push_i  = (c < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
         w3.aw_sel_i   = 2'($urandom_range(0, 3));
         w3.m_wvalid_i = ($urandom_range(0, 9) < 7);
         w3.m_wlast_i  = ($urandom_range(0, 9) < 4);
         w3.s_wready_i = 3'($urandom);
         w3.m_wdata_i  = $urandom;
         w3.m_wstrb_i  = 4'($urandom);
         settle();
         exp_sv3 = 3'b000;
         exp_wr3 = 1'b0;
         if (q.size() > 0) begin
            if (q[0] < 3) begin
               exp_sv3 = w3.m_wvalid_i ? (3'b001 << q[0]) : 3'b000;
               exp_wr3 = w3.s_wready_i[q[0]];
            end else begin
               exp_wr3 = 1'b1;
            end
         end
         chk("rnd_sv", 32'(w3.s_wvalid_o), 32'(exp_sv3));
         chk("rnd_wr", 32'(w3.m_wready_o), 32'(exp_wr3));
         chk("rnd_out", 32'(w3.outstanding_o), 32'(q.size()));
         chk("rnd_full", 32'(w3.aw_full_o), 32'(q.size() == 4));
         chk("rnd_ovf", 32'(w3.ovf_o), 32'(ovf_m));
         chk("rnd_decerr", 32'(w3.decerr_o), 32'(pend_decerr));
         chk("rnd_strb", 32'(w3.s_wstrb_o), 32'(w3.m_wstrb_i));
         pop_m = (q.size() > 0) && w3.m_wvalid_i && exp_wr3 && w3.m_wlast_i;
         acc_m = w3.aw_push_i && (q.size() < 4 || pop_m);
         pend_decerr = pop_m && (q[0] >= 3);
         if (w3.aw_push_i && !acc_m) ovf_m = 1'b1;
         if (pop_m) void'(q.pop_front());
         if (acc_m) q.push_back(int'(w3.aw_sel_i));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
